// File: rtl/serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : serial_pkg                                                   |
// | Description : Line-level constants, FSM state encoding and parity helper   |
// |               shared by the serial transmit and receive paths.             |
// | Contents    : deframe_state_e, LINE_IDLE/LINE_START/LINE_STOP,            |
// |               PARITY_EVEN, parity_match()                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package serial_pkg;

  // Frame sequencing states of the deframer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } deframe_state_e;

  // Line levels: an idle line sits low, a frame opens with a high start bit and
  // closes with a low stop bit.
  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP  = 1'b0;

  // XOR over data bits plus parity bit must equal this value (even parity).
  localparam logic PARITY_EVEN = 1'b0;

  // True when the parity bit is consistent with the XOR-reduced data word.
  function automatic logic parity_match(input logic data_xor, input logic parity_bit);
    return ((data_xor ^ parity_bit) == PARITY_EVEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_deframer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : serial_deframer_if                                           |
// | Description : Parallel output side of the serial deframer: received word   |
// |               with valid/ready handshake plus error reporting.             |
// | Signals     : data_out   [WIDTH]     received word                         |
// |               data_valid             holding register full                 |
// |               data_ready             consumer accepts the word             |
// |               parity_err/frame_err/overrun  one-cycle error pulses         |
// |               err_count  [ERR_CNT_W] saturating error-frame count          |
// | Modports    : master (deframer side), slave (consumer side)                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface serial_deframer_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
);

  logic [WIDTH-1:0]     data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready,
    output parity_err,
    output frame_err,
    output overrun,
    output err_count
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  err_count
  );

endinterface
`default_nettype wire

// File: rtl/deframe_hold_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : deframe_hold_reg                                             |
// | Description : WIDTH-bit output holding register with valid/ready.          |
// |               Arbitrates between loading a new good word, consumption by   |
// |               the downstream side and overrun when the register stays full.|
// | Ports       : clk, rst        clock, synchronous active-high reset         |
// |               i_load          a good word completes this cycle             |
// |               i_load_data     the completing word                          |
// |               i_ready         consumer ready                               |
// |               o_data/o_valid  held word and its valid flag                 |
// |               o_overrun       registered one-cycle overrun pulse           |
// |               o_lost          combinational: word is being dropped now     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module deframe_hold_reg #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_data,
  input  wire logic             i_ready,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_overrun,
  output logic                  o_lost
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_full_stays;

  // The register only stays occupied when it holds a word nobody takes this edge.
  assign w_full_stays = r_valid & ~i_ready;
  assign o_lost       = i_load & w_full_stays;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        if (w_full_stays) begin
          // Keep the unread word; the new one is lost.
          r_overrun <= 1'b1;
        end else begin
          // Either empty or being consumed on this same edge: replace.
          r_data  <= i_load_data;
          r_valid <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/serial_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_deframer                                              |
// | Description : Receive side of the one-bit-per-clock serial link. Hunts for |
// |               a start bit, shifts in WIDTH bits MSB-first, checks even     |
// |               parity and the stop bit, and hands good words to a           |
// |               valid/ready holding register. Bad or overrun frames are      |
// |               dropped, pulsed, and counted in a saturating counter.        |
// | Ports       : clk        clock, all logic on posedge                       |
// |               rst        synchronous active-high reset                     |
// |               serial_in  line input (idle 0, start 1, data, parity, stop 0)|
// |               dout       serial_deframer_if.master output bundle           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module serial_deframer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          serial_in,
  serial_deframer_if.master  dout
);

  localparam int                     CNT_W       = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]       C_LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [ERR_CNT_W-1:0]   C_ERR_MAX   = '1;

  deframe_state_e       r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [WIDTH-1:0]     r_shift;
  logic                 r_parity_ok;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_stop_ok;
  logic                 w_frame_done;
  logic                 w_good;
  logic                 w_bad;
  logic                 w_lost;
  logic                 w_count_evt;
  logic [WIDTH-1:0]     w_hold_data;
  logic                 w_hold_valid;
  logic                 w_hold_overrun;

  // Frame verdict is formed on the edge that samples the stop bit, so the
  // holding register can load on that very edge.
  assign w_stop_ok    = (serial_in == LINE_STOP);
  assign w_frame_done = (r_state == ST_STOP);
  assign w_good       = w_frame_done & w_stop_ok & r_parity_ok;
  assign w_bad        = w_frame_done & ~w_good;

  // Overrun can only hit a good frame, so it never coincides with w_bad and a
  // frame adds at most one to the counter.
  assign w_count_evt  = w_bad | w_lost;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity_ok  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (serial_in == LINE_START) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          r_shift   <= {r_shift[WIDTH-2:0], serial_in};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == C_LAST_BIT) begin
            r_state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          r_parity_ok <= parity_match(^r_shift, serial_in);
          r_state     <= ST_STOP;
        end
        ST_STOP: begin
          // A high stop bit is a framing error, never a new start bit.
          r_frame_err  <= ~w_stop_ok;
          r_parity_err <= ~r_parity_ok;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_count_evt && (r_err_count != C_ERR_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  deframe_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_good),
    .i_load_data (r_shift),
    .i_ready     (dout.data_ready),
    .o_data      (w_hold_data),
    .o_valid     (w_hold_valid),
    .o_overrun   (w_hold_overrun),
    .o_lost      (w_lost)
  );

  assign dout.data_out   = w_hold_data;
  assign dout.data_valid = w_hold_valid;
  assign dout.overrun    = w_hold_overrun;
  assign dout.parity_err = r_parity_err;
  assign dout.frame_err  = r_frame_err;
  assign dout.err_count  = r_err_count;

endmodule
`default_nettype wire
